// File: rtl/router_pkg.sv
// Shared definitions for the router output path: FSM encoding, header layout
// and small port-index helpers used by the scheduler and its arbiter.
package router_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        ABORT = 2'd2
    } sched_state_e;

    localparam int HDR_LEN_MSB = 7;
    localparam int HDR_LEN_LSB = 2;
    localparam int HDR_ADDR_W  = 2;
    localparam int NUM_PORTS   = 3;
    localparam int CNT_W       = 7;

    // Successor of a port index in the 0 -> 1 -> 2 -> 0 ring.
    function automatic logic [1:0] next_port(input logic [1:0] p);
        case (p)
            2'd0:    return 2'd1;
            2'd1:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [1:0] p);
        case (p)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Beats still owed after the header: the payload words plus the parity word.
    function automatic logic [CNT_W-1:0] hdr_beats(input logic [HDR_LEN_MSB:0] hdr);
        return {1'b0, hdr[HDR_LEN_MSB:HDR_LEN_LSB]} + 7'd1;
    endfunction

endpackage

// File: rtl/router_rr_arb3.sv
// Three-way rotating-priority encoder: the port after ptr is tried first and
// ptr itself is tried last.
module router_rr_arb3
    import router_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [1:0]           ptr,
    output logic [1:0]           gnt_idx,
    output logic                 gnt_any
);

    logic [1:0] cand1_s;
    logic [1:0] cand2_s;
    logic [1:0] cand3_s;

    // Walk the ring starting after ptr and take the first requesting port.
    always_comb begin
        cand1_s = next_port(ptr);
        cand2_s = next_port(cand1_s);
        cand3_s = next_port(cand2_s);
        gnt_idx = 2'd0;
        gnt_any = 1'b0;
        if (req[cand1_s]) begin
            gnt_idx = cand1_s;
            gnt_any = 1'b1;
        end else if (req[cand2_s]) begin
            gnt_idx = cand2_s;
            gnt_any = 1'b1;
        end else if (req[cand3_s]) begin
            gnt_idx = cand3_s;
            gnt_any = 1'b1;
        end else begin
            gnt_idx = 2'd0;
            gnt_any = 1'b0;
        end
    end

endmodule

// File: rtl/router_out_scheduler.sv
// Shares one downstream link between three show-ahead FIFOs, granting whole
// packets round-robin and aborting a packet that stalls for TIMEOUT cycles.
module router_out_scheduler
    import router_pkg::*;
#(
    parameter int DW      = 8,
    parameter int TIMEOUT = 30
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [DW-1:0]        fifo_dout_0,
    input  logic [DW-1:0]        fifo_dout_1,
    input  logic [DW-1:0]        fifo_dout_2,
    output logic [NUM_PORTS-1:0] fifo_rd_en,
    output logic [DW-1:0]        out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sop,
    output logic                 out_eop,
    output logic [NUM_PORTS-1:0] soft_reset,
    output logic [1:0]           grant,
    output logic                 busy
);

    localparam int STALL_W = $clog2(TIMEOUT);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
    localparam logic [STALL_W-1:0] STALL_MAX  = '1;

    sched_state_e         state_r;
    logic [1:0]           rr_ptr_r;
    logic [1:0]           grant_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [STALL_W-1:0]   stall_r;
    logic                 hdr_pending_r;
    logic [NUM_PORTS-1:0] soft_reset_r;

    logic [1:0]           arb_idx_s;
    logic                 arb_any_s;
    logic [DW-1:0]        head_s;
    logic                 head_valid_s;
    logic                 beat_s;

    router_rr_arb3 u_arb (
        .req     (~fifo_empty),
        .ptr     (rr_ptr_r),
        .gnt_idx (arb_idx_s),
        .gnt_any (arb_any_s)
    );

    // Select the head word and its valid flag of the granted FIFO.
    always_comb begin
        head_s       = '0;
        head_valid_s = 1'b0;
        case (grant_r)
            2'd0: begin
                head_s       = fifo_dout_0;
                head_valid_s = ~fifo_empty[0];
            end
            2'd1: begin
                head_s       = fifo_dout_1;
                head_valid_s = ~fifo_empty[1];
            end
            2'd2: begin
                head_s       = fifo_dout_2;
                head_valid_s = ~fifo_empty[2];
            end
            default: begin
                head_s       = '0;
                head_valid_s = 1'b0;
            end
        endcase
    end

    // Link-side outputs are live only while streaming; everything is quiet otherwise.
    always_comb begin
        out_valid  = 1'b0;
        out_data   = '0;
        out_sop    = 1'b0;
        out_eop    = 1'b0;
        fifo_rd_en = '0;
        beat_s     = 1'b0;
        if (state_r == XFER) begin
            out_valid = head_valid_s;
            out_data  = head_s;
            beat_s    = head_valid_s & out_ready;
            out_sop   = head_valid_s & hdr_pending_r;
            out_eop   = head_valid_s & ~hdr_pending_r & (cnt_r == 7'd1);
            if (beat_s) begin
                fifo_rd_en = port_onehot(grant_r);
            end else begin
                fifo_rd_en = '0;
            end
        end else begin
            out_valid  = 1'b0;
            out_data   = '0;
            fifo_rd_en = '0;
        end
    end

    // Packet FSM with beat counter, stall watchdog and round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= IDLE;
            rr_ptr_r      <= 2'd2;
            grant_r       <= 2'd0;
            cnt_r         <= '0;
            stall_r       <= '0;
            hdr_pending_r <= 1'b0;
            soft_reset_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    soft_reset_r <= '0;
                    if (arb_any_s) begin
                        grant_r       <= arb_idx_s;
                        hdr_pending_r <= 1'b1;
                        stall_r       <= '0;
                        state_r       <= XFER;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                XFER: begin
                    if (beat_s) begin
                        stall_r      <= '0;
                        soft_reset_r <= '0;
                        if (hdr_pending_r) begin
                            hdr_pending_r <= 1'b0;
                            cnt_r         <= hdr_beats(head_s[HDR_LEN_MSB:0]);
                        end else if (cnt_r == 7'd1) begin
                            cnt_r    <= '0;
                            rr_ptr_r <= grant_r;
                            state_r  <= IDLE;
                        end else begin
                            cnt_r <= cnt_r - 7'd1;
                        end
                    end else if (stall_r == STALL_LAST) begin
                        // Registered so the flush pulse lines up with the ABORT cycle.
                        soft_reset_r <= port_onehot(grant_r);
                        state_r      <= ABORT;
                    end else begin
                        soft_reset_r <= '0;
                        if (stall_r != STALL_MAX) begin
                            stall_r <= stall_r + STALL_W'(1);
                        end else begin
                            stall_r <= stall_r;
                        end
                    end
                end
                ABORT: begin
                    soft_reset_r  <= '0;
                    rr_ptr_r      <= grant_r;
                    cnt_r         <= '0;
                    stall_r       <= '0;
                    hdr_pending_r <= 1'b0;
                    state_r       <= IDLE;
                end
                default: begin
                    soft_reset_r <= '0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign soft_reset = soft_reset_r;
    assign grant      = grant_r;
    assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_router_out_scheduler.sv
// Directed bench for router_out_scheduler: a FIFO model feeds packets, a
// scoreboard queue holds expected link beats and a negedge monitor checks them.
module tb_router_out_scheduler;

    logic       clock;
    logic       reset;
    logic [2:0] fifo_empty;
    logic [7:0] fifo_dout_0, fifo_dout_1, fifo_dout_2;
    logic [2:0] fifo_rd_en;
    logic [7:0] out_data;
    logic       out_valid, out_ready, out_sop, out_eop;
    logic [2:0] soft_reset;
    logic [1:0] grant;
    logic       busy;

    router_out_scheduler #(.DW(8), .TIMEOUT(30)) dut (
        .clock(clock), .reset(reset), .fifo_empty(fifo_empty),
        .fifo_dout_0(fifo_dout_0), .fifo_dout_1(fifo_dout_1), .fifo_dout_2(fifo_dout_2),
        .fifo_rd_en(fifo_rd_en), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
        .soft_reset(soft_reset), .grant(grant), .busy(busy)
    );

    typedef struct {
        logic [1:0] port;
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } beat_t;

    beat_t      sb[$];
    logic [2:0] sr_q[$];
    logic [7:0] q0[$], q1[$], q2[$];
    logic [2:0] rd_s = 3'b000;
    logic [2:0] sr_s = 3'b000;
    logic       hold_chk = 1'b0;
    logic       eop_prev = 1'b0;
    beat_t      e;
    int         n_vec = 0;
    int         n_err = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pkt_word(input logic [7:0] hdr, input logic [7:0] base, input int i);
        int         len;
        logic [7:0] par;
        len = int'(hdr[7:2]);
        par = hdr ^ 8'hA5;
        for (int k = 1; k <= len; k++) par = par ^ (base + 8'(k));
        if (i == 0) return hdr;
        else if (i <= len) return base + 8'(i);
        else return par;
    endfunction

    task automatic refresh();
        fifo_empty  = {q2.size() == 0, q1.size() == 0, q0.size() == 0};
        fifo_dout_0 = (q0.size() != 0) ? q0[0] : 8'h00;
        fifo_dout_1 = (q1.size() != 0) ? q1[0] : 8'h00;
        fifo_dout_2 = (q2.size() != 0) ? q2[0] : 8'h00;
    endtask

    task automatic fpush(input int p, input logic [7:0] w);
        case (p)
            0:       q0.push_back(w);
            1:       q1.push_back(w);
            default: q2.push_back(w);
        endcase
    endtask

    // FIFO model: pops/flushes seen by the monitor take effect just after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
        if (sr_s[0]) q0.delete(); else if (rd_s[0] && q0.size() != 0) void'(q0.pop_front());
        if (sr_s[1]) q1.delete(); else if (rd_s[1] && q1.size() != 0) void'(q1.pop_front());
        if (sr_s[2]) q2.delete(); else if (rd_s[2] && q2.size() != 0) void'(q2.pop_front());
        refresh();
        #2;
    endtask

    task automatic load(input int p, input logic [7:0] hdr, input logic [7:0] base);
        for (int i = 0; i <= int'(hdr[7:2]) + 1; i++) fpush(p, pkt_word(hdr, base, i));
        refresh();
    endtask

    task automatic expect_pkt(input int p, input logic [7:0] hdr, input logic [7:0] base, input int nb);
        int last;
        beat_t b;
        last = int'(hdr[7:2]) + 1;
        for (int i = 0; i < ((nb < 0) ? last + 1 : nb); i++) begin
            b.port = 2'(p);
            b.data = pkt_word(hdr, base, i);
            b.sop  = (i == 0);
            b.eop  = (i == last);
            sb.push_back(b);
        end
    endtask

    task automatic drain(input string nm, input int maxc);
        int c;
        c = 0;
        while (sb.size() != 0 && c < maxc) begin
            tick();
            c++;
        end
        chk({nm, "_drain"}, sb.size(), 0);
        tick();
    endtask

    // Monitor: compares every link beat and flush pulse against the scoreboard.
    always @(negedge clock) begin
        rd_s = fifo_rd_en;
        sr_s = soft_reset;
        if (eop_prev) chk("busy_after_eop", {31'd0, busy}, 32'd0);
        eop_prev = 1'b0;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: data 0x%0h on grant %0d with nothing expected at %0t",
                         out_data, grant, $time);
            end else begin
                e = sb.pop_front();
                chk("beat_data",  {24'd0, out_data},   {24'd0, e.data});
                chk("beat_grant", {30'd0, grant},      {30'd0, e.port});
                chk("beat_sop",   {31'd0, out_sop},    {31'd0, e.sop});
                chk("beat_eop",   {31'd0, out_eop},    {31'd0, e.eop});
                chk("beat_rd_en", {29'd0, fifo_rd_en}, {29'd0, 3'b001 << e.port});
                eop_prev = e.eop;
            end
        end else if (out_valid === 1'b1) begin
            chk("stall_rd_en", {29'd0, fifo_rd_en}, 32'd0);
            if (hold_chk && sb.size() != 0) chk("hold_data", {24'd0, out_data}, {24'd0, sb[0].data});
        end
        if (soft_reset != 3'b000) begin
            if (sr_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_soft_reset: got 0x%0h, expected none at %0t", soft_reset, $time);
            end else begin
                chk("soft_reset", {29'd0, soft_reset}, {29'd0, sr_q.pop_front()});
            end
            chk("abort_valid", {31'd0, out_valid}, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        refresh();
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_valid",  {31'd0, out_valid},             32'd0);
        chk("rst_busy",   {31'd0, busy},                  32'd0);
        chk("rst_grant",  {30'd0, grant},                 32'd0);
        chk("rst_sreset", {29'd0, soft_reset},            32'd0);
        chk("rst_rd_en",  {29'd0, fifo_rd_en},            32'd0);
        chk("rst_sopeop", {30'd0, out_sop, out_eop},      32'd0);
        chk("rst_data",   {24'd0, out_data},              32'd0);

        // Round robin from reset: 0, 1, 2, then 0 again.
        load(0, 8'h04, 8'h10); load(1, 8'h04, 8'h18); load(2, 8'h04, 8'h1C); load(0, 8'h04, 8'h30);
        expect_pkt(0, 8'h04, 8'h10, -1); expect_pkt(1, 8'h04, 8'h18, -1);
        expect_pkt(2, 8'h04, 8'h1C, -1); expect_pkt(0, 8'h04, 8'h30, -1);
        drain("rr", 100);

        // Single len-2 packet on FIFO1: four back-to-back beats, idle right after.
        load(1, 8'h09, 8'hA0);
        expect_pkt(1, 8'h09, 8'hA0, -1);
        repeat (5) tick();
        chk("len2_done", sb.size(), 0);
        chk("len2_idle", {31'd0, busy}, 32'd0);

        // Five-cycle back-pressure mid-payload on FIFO2.
        load(2, 8'h0C, 8'h20);
        expect_pkt(2, 8'h0C, 8'h20, -1);
        tick();
        tick();
        out_ready = 1'b0;
        hold_chk  = 1'b1;
        repeat (5) tick();
        out_ready = 1'b1;
        hold_chk  = 1'b0;
        drain("stall5", 50);

        // Thirty stall cycles after the header abort FIFO0; FIFO1 is served next.
        load(0, 8'h08, 8'h40);
        load(1, 8'h04, 8'h50);
        expect_pkt(0, 8'h08, 8'h40, 1);
        expect_pkt(1, 8'h04, 8'h50, -1);
        sr_q.push_back(3'b001);
        tick();
        tick();
        out_ready = 1'b0;
        repeat (29) tick();
        chk("abort_not_early", {29'd0, soft_reset}, 32'd0);
        chk("abort_busy_pre",  {31'd0, busy},       32'd1);
        tick();
        chk("abort_pulse",     {29'd0, soft_reset}, 32'd1);
        chk("abort_busy",      {31'd0, busy},       32'd1);
        out_ready = 1'b1;
        tick();
        chk("abort_pulse_end", {29'd0, soft_reset}, 32'd0);
        chk("abort_idle",      {31'd0, busy},       32'd0);
        drain("abort_next", 50);

        // Handshake on the 30th stall cycle wins, twice in a row.
        load(2, 8'h04, 8'h60);
        expect_pkt(2, 8'h04, 8'h60, -1);
        tick();
        tick();
        out_ready = 1'b0;
        repeat (29) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (29) tick();
        chk("edge_no_abort", {31'd0, busy}, 32'd1);
        out_ready = 1'b1;
        drain("edge", 20);

        // Zero-length packet: header then parity.
        load(0, 8'h01, 8'h00);
        expect_pkt(0, 8'h01, 8'h00, -1);
        repeat (3) tick();
        chk("len0_done", sb.size(), 0);
        chk("len0_idle", {31'd0, busy}, 32'd0);

        // Reset mid-payload, then arbitration restarts from port 0.
        load(1, 8'h0C, 8'h70);
        expect_pkt(1, 8'h0C, 8'h70, 2);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_valid",  {31'd0, out_valid},        32'd0);
        chk("mid_rst_busy",   {31'd0, busy},             32'd0);
        chk("mid_rst_grant",  {30'd0, grant},            32'd0);
        chk("mid_rst_rd_en",  {29'd0, fifo_rd_en},       32'd0);
        chk("mid_rst_sreset", {29'd0, soft_reset},       32'd0);
        chk("mid_rst_sopeop", {30'd0, out_sop, out_eop}, 32'd0);
        chk("mid_rst_sb",     sb.size(),                 32'd0);
        q1.delete();
        reset = 1'b0;
        load(1, 8'h04, 8'h80);
        load(0, 8'h04, 8'h90);
        expect_pkt(0, 8'h04, 8'h90, -1);
        expect_pkt(1, 8'h04, 8'h80, -1);
        refresh();
        drain("post_rst", 50);

        chk("sr_q_left", sr_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
